ads131_frame_sequencer: RTL
===========================

// Module: ads131_frame_sequencer
// PURPOSE
//  Sequences the ADS131A0x SPI word-transaction engine. After start it runs a fixed init command list and checks each
//  response, then arms on DRDY. For every DRDY fall it reads one status word plus NUM_CH channel words and presents
//  them as one frame on a valid/ready port. It is the only requester of the SPI word engine.
// PARAMETERS
//  NUM_CH     4     channel words per frame (1..4)
//  WORD_BITS  24    SPI word width; commands occupy bits [WORD_BITS-1 -: 16], LSBs zero
//  ACK_TMO    1023  max cycles xfer_req may wait for xfer_ack before error
// PORTS
//  system_clock  in   1                 system clock, 50 MHz
//  reset         in   1                 asynchronous, active-high reset
//  start         in   1                 1-cycle pulse: (re)start init sequence; clears error/overrun
//  drdy_n        in   1                 ADC DRDY, active-low, asynchronous (2-flop synchronised inside)
//  xfer_req      out  1                 word transaction request to SPI engine
//  xfer_cmd      out  16                command word sent on MOSI for this transaction
//  xfer_ack      in   1                 1-cycle pulse: transaction done, xfer_rdata valid
//  xfer_rdata    in   WORD_BITS         word received on MISO
//  frame_valid   out  1                 frame_data/frame_status valid
//  frame_ready   in   1                 consumer accepts frame
//  frame_data    out  NUM_CH*WORD_BITS  ch0 in LSBs
//  frame_status  out  16                status word (rdata[WORD_BITS-1 -: 16])
//  init_done     out  1                 init list completed, all responses correct
//  error         out  1                 sticky: bad init response or ack timeout
//  overrun       out  1                 sticky: frame overwritten before accepted
//  state         out  3                 current FSM state (debug)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, frame buffer 0, drdy synchroniser 1s. Applies mid-transaction; SPI engine is
//   not told, and any later xfer_ack is ignored outside WAIT states.
//  Handshake: xfer_req rises with a valid xfer_cmd and holds both stable until the xfer_ack cycle. The cycle after ack
//   it is 0 for at least 1 cycle before the next request. An ack with xfer_req=0 is ignored.
//  Timeout: a counter clears on each request and counts while waiting. At ACK_TMO without ack -> ERROR, error=1.
//  Init ROM (idx 0..4): 0x0655 UNLOCK, 0x4B68 WREG A_SYS_CFG, 0x4D02 WREG CLK1, 0x4F0F WREG ADC_ENA,
//   0x0033 WAKEUP. Expected responses: 0x0655, 0x2B68, 0x2D02, 0x2F0F, 0x0033.
//  States:
//   IDLE(0): start -> CMD, idx=0.
//   CMD(1): issue ROM[idx]; on ack -> RSP.
//   RSP(2): issue 0x0000 (NULL). On ack compare rdata[WORD_BITS-1 -: 16] to expected.
//     Mismatch -> ERROR. Match and idx<4 -> CMD with idx+1. Match and idx=4 -> ARMED, init_done=1.
//   ARMED(3): on synchronised drdy_n 1->0 edge -> READ, word count k=0.
//   READ(4): issue 0x0000. On ack store word k: k=0 status, k>=1 channel k-1. Done after k=NUM_CH -> commit, ARMED.
//   ERROR(5): xfer_req=0, init_done=0; only start or reset leave.
//  start in any state -> CMD idx=0; clears error, overrun, init_done, frame_valid. An outstanding ack is dropped.
//  DRDY edges outside ARMED are ignored and not queued.
//  Frame port:
//   - Channel words fill a shadow buffer. Commit copies shadow to frame_data/frame_status and sets frame_valid.
//   - frame_valid=1 and frame_ready=1 clears frame_valid next cycle.
//   - Commit while frame_valid=1 and not accepted that cycle: data overwritten, frame_valid stays 1, overrun=1.
//   - Commit and accept in the same cycle: new data loaded, frame_valid stays 1, no overrun.
//  Latency: commit lands the cycle after the last ack. DRDY to first xfer_req is 3 cycles (2 sync + edge detect).
// TESTING
//  1 Init OK: start, SPI model echoes expected words -> 10 transactions with cmds 0655,0000,4B68,0000,...,0033,0000;
//    init_done=1, state=3.
//  2 Bad response: idx2 response 0x2D03 -> error=1, state=5, no further xfer_req. Then start -> sequence restarts at 0x0655.
//  3 Frame read, NUM_CH=4: drdy_n fall, rdata status 0x2200, ch 0x111111..0x444444 -> frame_valid after 5 acks;
//    frame_data={444444,333333,222222,111111}, status 0x2200.
//  4 Overrun: frame_ready=0, two DRDY frames -> second frame data shown, overrun=1, frame_valid=1. Commit and ready
//    in the same cycle -> overrun unchanged.
//  5 Timeout: withhold xfer_ack -> error=1 exactly ACK_TMO cycles after xfer_req rose; late ack ignored.
//  6 Reset mid-READ after 2 acks -> all outputs 0 same cycle. Release, start -> clean init, no stale frame_valid.

Source files
------------

// File: rtl/ads131_frame_sequencer.sv
// Request sequencer for the ADS131A0x SPI word engine: runs the init command list, then reads one
// status word plus NUM_CH channel words per DRDY fall and presents them as a valid/ready frame.
module ads131_frame_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int WORD_BITS = 24,
    parameter int ACK_TMO   = 1023
) (
    input  logic                        system_clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        drdy_n,
    output logic                        xfer_req,
    output logic [15:0]                 xfer_cmd,
    input  logic                        xfer_ack,
    input  logic [WORD_BITS-1:0]        xfer_rdata,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [NUM_CH*WORD_BITS-1:0] frame_data,
    output logic [15:0]                 frame_status,
    output logic                        init_done,
    output logic                        error,
    output logic                        overrun,
    output logic [2:0]                  state
);

    localparam int TMO_W = $clog2(ACK_TMO + 1);
    localparam int KW    = $clog2(NUM_CH + 1);
    localparam int FW    = NUM_CH * WORD_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        RSP   = 3'd2,
        ARMED = 3'd3,
        READ  = 3'd4,
        ERROR = 3'd5
    } state_t;

    function automatic logic [15:0] rom_cmd(input logic [2:0] i);
        case (i)
            3'd0:    rom_cmd = 16'h0655;
            3'd1:    rom_cmd = 16'h4B68;
            3'd2:    rom_cmd = 16'h4D02;
            3'd3:    rom_cmd = 16'h4F0F;
            default: rom_cmd = 16'h0033;
        endcase
    endfunction

    function automatic logic [15:0] rom_rsp(input logic [2:0] i);
        case (i)
            3'd0:    rom_rsp = 16'h0655;
            3'd1:    rom_rsp = 16'h2B68;
            3'd2:    rom_rsp = 16'h2D02;
            3'd3:    rom_rsp = 16'h2F0F;
            default: rom_rsp = 16'h0033;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [KW-1:0]    k_q, k_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             req_q, req_d;
    logic [15:0]      cmd_q, cmd_d;
    logic [FW-1:0]    shadow_q, shadow_d;
    logic [15:0]      sh_status_q, sh_status_d;
    logic [FW-1:0]    data_q, data_d;
    logic [15:0]      status_q, status_d;
    logic             valid_q, valid_d;
    logic             init_done_q, init_done_d;
    logic             error_q, error_d;
    logic             overrun_q, overrun_d;
    logic [2:0]       drdy_sync_q, drdy_sync_d;

    logic [15:0] rsp_word;
    logic        drdy_fall;
    logic        commit;

    assign rsp_word  = xfer_rdata[WORD_BITS-1 -: 16];
    // Bit 2 is the edge-detect stage: a fall is old-high, new-low.
    assign drdy_fall = drdy_sync_q[2] & ~drdy_sync_q[1];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        tmo_d       = tmo_q;
        req_d       = req_q;
        cmd_d       = cmd_q;
        shadow_d    = shadow_q;
        sh_status_d = sh_status_q;
        data_d      = data_q;
        status_d    = status_q;
        valid_d     = valid_q;
        init_done_d = init_done_q;
        error_d     = error_q;
        overrun_d   = overrun_q;
        drdy_sync_d = {drdy_sync_q[1:0], drdy_n};
        commit      = 1'b0;

        if (start) begin
            state_d     = CMD;
            idx_d       = 3'd0;
            req_d       = 1'b0;
            tmo_d       = '0;
            valid_d     = 1'b0;
            init_done_d = 1'b0;
            error_d     = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (valid_q && frame_ready) valid_d = 1'b0;

            unique case (state_q)
                IDLE: ;
                CMD, RSP, READ: begin
                    if (!req_q) begin
                        req_d = 1'b1;
                        cmd_d = (state_q == CMD) ? rom_cmd(idx_q) : 16'h0000;
                        tmo_d = '0;
                    end else if (xfer_ack) begin
                        req_d = 1'b0;
                        if (state_q == CMD) begin
                            state_d = RSP;
                        end else if (state_q == RSP) begin
                            if (rsp_word != rom_rsp(idx_q)) begin
                                state_d = ERROR;
                            end else if (idx_q == 3'd4) begin
                                state_d     = ARMED;
                                init_done_d = 1'b1;
                            end else begin
                                idx_d   = idx_q + 3'd1;
                                state_d = CMD;
                            end
                        end else begin
                            if (k_q == '0) sh_status_d = rsp_word;
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (k_q == KW'(c + 1)) shadow_d[c*WORD_BITS +: WORD_BITS] = xfer_rdata;
                            end
                            if (k_q == KW'(NUM_CH)) begin
                                commit  = 1'b1;
                                state_d = ARMED;
                            end else begin
                                k_d = k_q + KW'(1);
                            end
                        end
                    end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
                        state_d = ERROR;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ARMED: begin
                    // Request goes out on the edge-detect cycle itself to hit the 3-cycle DRDY latency.
                    if (drdy_fall) begin
                        state_d = READ;
                        k_d     = '0;
                        req_d   = 1'b1;
                        cmd_d   = 16'h0000;
                        tmo_d   = '0;
                    end
                end
                ERROR: ;
                default: state_d = IDLE;
            endcase

            if (state_d == ERROR) begin
                req_d       = 1'b0;
                init_done_d = 1'b0;
                error_d     = 1'b1;
            end

            if (commit) begin
                data_d   = shadow_d;
                status_d = sh_status_d;
                if (valid_q && !frame_ready) overrun_d = 1'b1;
                valid_d  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            k_q         <= '0;
            tmo_q       <= '0;
            req_q       <= 1'b0;
            cmd_q       <= '0;
            shadow_q    <= '0;
            sh_status_q <= '0;
            data_q      <= '0;
            status_q    <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            overrun_q   <= 1'b0;
            drdy_sync_q <= 3'b111;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            req_q       <= req_d;
            cmd_q       <= cmd_d;
            shadow_q    <= shadow_d;
            sh_status_q <= sh_status_d;
            data_q      <= data_d;
            status_q    <= status_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
            overrun_q   <= overrun_d;
            drdy_sync_q <= drdy_sync_d;
        end
    end

    assign xfer_req     = req_q;
    assign xfer_cmd     = cmd_q;
    assign frame_valid  = valid_q;
    assign frame_data   = data_q;
    assign frame_status = status_q;
    assign init_done    = init_done_q;
    assign error        = error_q;
    assign overrun      = overrun_q;
    assign state        = state_q;

endmodule
